rst_seq_ctrl: RTL

Reset sequencer between the pad ring / housekeeping SPI and the retrosoc core, replacing the plain AND of button reset and housekeeping reset. It synchronises and debounces the button reset and synchronises the housekeeping reset. It optionally converts a core trap into a reset and records the reset cause. Peripheral reset is released before core reset, each after a fixed stretch.

---
 rtl/rst_seq_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer between pad ring / housekeeping and core.
// Filters reset requests, records their cause, releases periph then core.
module rst_seq_ctrl #(
    parameter int DEBOUNCE_CYC = 16,
    parameter int STRETCH_CYC  = 64,
    parameter int PERIPH_DLY   = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_n_i,
    input  logic       hk_rst_i,
    input  logic       trap_i,
    input  logic       trap_rst_en_i,
    input  logic       cause_clr_i,
    output logic       periph_rst_n_o,
    output logic       core_rst_n_o,
    output logic [3:0] rst_cause_o,
    output logic       busy_o
);

    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int CMAX = (STRETCH_CYC > PERIPH_DLY) ?
                          STRETCH_CYC : PERIPH_DLY;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] STR_LOAD = CW'(STRETCH_CYC - 1);
    localparam logic [CW-1:0] PER_LOAD = CW'(PERIPH_DLY - 1);

    typedef enum logic [1:0] {
        HOLD,
        STRETCH,
        PERIPH,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic          btn_s1;
    logic          btn_s2;
    logic          hk_s1;
    logic          hk_s2;

    logic          btn_req;
    logic [DW-1:0] db_cnt;
    logic          btn_mis;

    logic          hk_req;
    logic          trap_req;
    logic          trap_hit;
    logic          ext_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1 <= 1'b1;
            btn_s2 <= 1'b1;
            hk_s1  <= 1'b0;
            hk_s2  <= 1'b0;
        end else begin
            btn_s1 <= btn_rst_n_i;
            btn_s2 <= btn_s1;
            hk_s1  <= hk_rst_i;
            hk_s2  <= hk_s1;
        end
    end

    // Pad is active-low while btn_req is active-high, so equality means mismatch.
    assign btn_mis = (btn_s2 == btn_req);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_req <= 1'b0;
            db_cnt  <= '0;
        end else if (!btn_mis) begin
            db_cnt  <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_req <= ~btn_req;
            db_cnt  <= '0;
        end else begin
            db_cnt  <= db_cnt + 1'b1;
        end
    end

    assign hk_req   = hk_s2;
    assign trap_req = trap_i & trap_rst_en_i;
    assign trap_hit = trap_req & (state == RUN);
    assign ext_req  = btn_req | hk_req;

    // A set on the same edge as a clear wins for that bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cause_o <= 4'b0001;
        end else begin
            rst_cause_o <= (cause_clr_i ? 4'b0000 : rst_cause_o)
                         | {trap_hit, hk_req, btn_req, 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= HOLD;
            cnt            <= '0;
            periph_rst_n_o <= 1'b0;
            core_rst_n_o   <= 1'b0;
            busy_o         <= 1'b1;
        end else begin
            unique case (state)
                HOLD: begin
                    if (!ext_req) begin
                        state <= STRETCH;
                        cnt   <= STR_LOAD;
                    end
                end
                STRETCH: begin
                    if (ext_req) begin
                        state <= HOLD;
                    end else if (cnt == '0) begin
                        state          <= PERIPH;
                        periph_rst_n_o <= 1'b1;
                        cnt            <= PER_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PERIPH: begin
                    if (ext_req) begin
                        state          <= HOLD;
                        periph_rst_n_o <= 1'b0;
                    end else if (cnt == '0) begin
                        state        <= RUN;
                        core_rst_n_o <= 1'b1;
                        busy_o       <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (ext_req | trap_req) begin
                        state          <= HOLD;
                        periph_rst_n_o <= 1'b0;
                        core_rst_n_o   <= 1'b0;
                        busy_o         <= 1'b1;
                    end
                end
                default: begin
                    state          <= HOLD;
                    periph_rst_n_o <= 1'b0;
                    core_rst_n_o   <= 1'b0;
                    busy_o         <= 1'b1;
                end
            endcase
        end
    end

endmodule
